intr_ctrl: RTL
==============

# intr_ctrl

Interrupt controller sitting directly upstream of the CPU control unit. It synchronises and edge-detects eight external interrupt lines, latches them as pending, and presents two one-hot priority vectors to the control unit: `min_bit_s`, the highest-priority pending request, and `min_bit_a`, the highest-priority interrupt in service. It consumes the control unit's `s_call_intr` and `s_return_intr` one-hot strobes to move requests from pending to in-service and to retire them. Bit 0 has the highest priority; a numerically smaller one-hot value means higher priority, which is the comparison the control unit performs.

## Interface
- `N_IRQ`, default 8: number of interrupt lines. It is fixed at 8 to match the control-unit port widths.
- `MASK_RST`, default 8'hFF: reset value of the enable mask.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_in`  in  8  asynchronous external interrupt lines; a rising edge is a request.
- `mask_we`  in  1  write strobe for the enable mask.
- `mask_wdata`  in  8  new mask value; 1 = line enabled.
- `s_call_intr`  in  8  one-hot strobe from the control unit: accept this request.
- `s_return_intr`  in  8  one-hot strobe from the control unit: retire this interrupt.
- `min_bit_s`  out  8  one-hot lowest-index bit of `pending & mask`; 0 when none.
- `min_bit_a`  out  8  one-hot lowest-index bit of `in_service`; 0 when none.
- `pending`  out  8  pending-request register, exposed as status.
- `in_service`  out  8  in-service register, exposed as status.
- `mask`  out  8  current enable mask.

## Operation
- **Synchroniser.** Each line passes through a two-flop chain (`s1`, `s2`) followed by a history flop `s3`.
- **Edge detect.** `rise = s2 & ~s3`.
- **Pending update.** `pending <= (pending & ~s_call_intr) | rise`.
  - A new edge on the same bit as a call re-pends that bit; set wins.
- **In-service update.** `in_service <= (in_service & ~s_return_intr) | s_call_intr`.
  - If the same bit is both returned and called, it stays set.
- **Nesting.** Multiple in-service bits are legal.
  - `min_bit_a` always reports the highest-priority active bit.
  - After a return, the next-lower active interrupt resumes being reported in the same cycle that the register updates.
- **Mask.**
  - `mask_we` loads `mask_wdata` at the clock edge.
  - Masked lines still latch into `pending` but are excluded from `min_bit_s`.
  - Unmasking a line that is already pending presents it the cycle after the write.
- **Strobe widths.** Strobes are applied bitwise, with no one-hot check.
  - A zero strobe is a no-op.
  - A call on a bit that is not pending still sets `in_service` for that bit.
- **Priority outputs.** `min_bit_s` and `min_bit_a` are combinational functions of registered state only (`x & (~x + 1)`). They have no combinational path from any input.

## Timing
- **Reset.** Registers take these values at the first rising edge with `reset = 1`; `reset` overrides `mask_we` and both strobes.
  - `s1`, `s2`, `s3`, `pending` and `in_service` clear to 0.
  - `mask` loads `MASK_RST`.
  - Outputs therefore reset to: `pending`, `in_service`, `min_bit_s`, `min_bit_a` = 0; `mask` = 8'hFF.
- **Line high at reset release.** A line that is high when reset is released is seen as a rising edge and becomes pending 3 edges later.
- **Request latency.** For a line that rises before edge k:
  - `s1` = 1 after edge k.
  - `s2` = 1 after edge k+1, so `rise` is asserted in cycle k+1.
  - `pending` is set at edge k+2, and `min_bit_s` is valid after edge k+2.
- **Minimum pulse.** A pulse must be high for at least 2 clock periods to be guaranteed capture. Repeated edges while a bit is pending merge into one request.
- **Call/return latency.** `s_call_intr` asserted in cycle c updates `pending` and `in_service` at edge c+1, so `min_bit_s` and `min_bit_a` change in cycle c+1.
  - The control unit asserts `s_call_intr` for exactly one cycle per accepted interrupt, because `min_bit_a` is at least as high priority from the next cycle.
- **Reset mid-operation.** Pending and in-service requests are discarded.

## Structure
- **Package `intr_pkg`:**
  - `N_IRQ = 8`
  - `MASK_RST = 8'hFF`
  - typedef `irq_vec_t` = `logic [N_IRQ-1:0]`
- **Sub-module `lsb_onehot`:** combinational; in `irq_vec_t`, out `irq_vec_t` = lowest set bit. It is instantiated twice, once for `min_bit_s` and once for `min_bit_a`.
- **Top `intr_ctrl`:** synchroniser, edge detect, `pending`/`in_service`/`mask` registers.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `irq_in` = 0 -> all status = 0, `mask` = 8'hFF, both `min_bit` outputs = 0.
- **Single request:** raise `irq_in[3]` before edge k -> `pending` = 8'h08 and `min_bit_s` = 8'h08 after edge k+2, not earlier. Then pulse `s_call_intr` = 8'h08 for 1 cycle -> `pending` = 0, `in_service` = 8'h08, `min_bit_a` = 8'h08.
- **Priority and nesting:**
  - Raise lines 5 and 2 together -> `min_bit_s` = 8'h04.
  - Call 8'h04 -> `min_bit_s` = 8'h20, `min_bit_a` = 8'h04.
  - Call 8'h20 -> `in_service` = 8'h24, `min_bit_a` = 8'h04.
  - Return 8'h04 -> `min_bit_a` = 8'h20.
  - Return 8'h20 -> `min_bit_a` = 0.
- **Mask:**
  - Write `mask` = 8'hFE, then raise `irq_in[0]` -> `pending` = 8'h01, `min_bit_s` = 0.
  - Write `mask` = 8'hFF -> `min_bit_s` = 8'h01 the next cycle.
- **Simultaneous events:** with bit 1 pending, assert `s_call_intr` = 8'h02 in the same cycle `rise[1]` = 1 -> `pending[1]` stays 1, `in_service[1]` = 1. Also drive the same bit as return and call in one cycle -> `in_service` bit stays 1.
- **Reset mid-operation:** with `pending` = 8'h11 and `in_service` = 8'h02, assert `reset` for 1 cycle -> all cleared next cycle, `mask` = 8'hFF. A line held high through reset -> pending 3 edges after release.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared sizing, reset values and vector type for the interrupt controller.
package intr_pkg;

  localparam int N_IRQ = 8;
  localparam logic [N_IRQ-1:0] MASK_RST = 8'hFF;

  typedef logic [N_IRQ-1:0] irq_vec_t;

endpackage

// File: rtl/lsb_onehot.sv
// Isolates the lowest set bit of a vector as a one-hot value (0 when none).
// Bit 0 is the highest priority, so this is the priority encoder used by the
// controller for both the request and the in-service outputs.
module lsb_onehot
  import intr_pkg::*;
(
  input  irq_vec_t vec,
  output irq_vec_t lsb
);

  // Two's-complement trick: x & -x keeps only the lowest set bit.
  always_comb begin
    lsb = vec & (~vec + irq_vec_t'(1));
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises and edge-detects the external lines,
// tracks pending and in-service requests, and presents one-hot priority
// vectors to the CPU control unit. Priority outputs depend on registered
// state only, so there is no combinational path from any input to them.
module intr_ctrl #(
  parameter int               N_IRQ    = intr_pkg::N_IRQ,
  parameter logic [N_IRQ-1:0] MASK_RST = intr_pkg::MASK_RST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic [N_IRQ-1:0] s_call_intr,
  input  logic [N_IRQ-1:0] s_return_intr,
  output logic [N_IRQ-1:0] min_bit_s,
  output logic [N_IRQ-1:0] min_bit_a,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] mask
);

  import intr_pkg::*;

  logic [N_IRQ-1:0] s1;
  logic [N_IRQ-1:0] s2;
  logic [N_IRQ-1:0] s3;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_masked;

  // Two-flop synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A request is a synchronised low-to-high transition.
  always_comb begin
    rise = s2 & ~s3;
  end

  // Pending: a call clears its bit, but a fresh edge on the same bit wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~s_call_intr) | rise;
    end
  end

  // In-service: a call sets its bit even if the same bit is being returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_service <= '0;
    end else begin
      in_service <= (in_service & ~s_return_intr) | s_call_intr;
    end
  end

  // Enable mask; masked lines still pend but are hidden from min_bit_s.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= MASK_RST;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // Only enabled pending requests compete for priority.
  always_comb begin
    pending_masked = pending & mask;
  end

  lsb_onehot u_min_s (
    .vec (pending_masked),
    .lsb (min_bit_s)
  );

  lsb_onehot u_min_a (
    .vec (in_service),
    .lsb (min_bit_a)
  );

endmodule
